// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 move controller: board geometry, tile values,
// FSM encodings, direction codes and the line-element addressing helpers.
package game_pkg;

   localparam int unsigned BoardDim  = 4;
   localparam int unsigned TileWidth = 12;
   localparam logic [TileWidth-1:0] WinTile   = 12'd2048;
   localparam logic [TileWidth-1:0] SpawnTile = 12'd2;

   typedef logic [TileWidth-1:0] tile_t;
   typedef tile_t [BoardDim-1:0] line_t;
   typedef line_t [BoardDim-1:0] board_t;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLine  = 3'd1,
      StSpawn = 3'd2,
      StWrite = 3'd3,
      StWin   = 3'd4,
      StLose  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      DirLeft  = 2'd0,
      DirRight = 2'd1,
      DirUp    = 2'd2,
      DirDown  = 2'd3
   } dir_e;

   // Element 0 of a line is the cell tiles slide toward for the given direction.
   function automatic logic [1:0] cell_row(dir_e dir, logic [1:0] line, logic [1:0] elem);
      case (dir)
         DirLeft, DirRight: return line;
         DirUp:             return elem;
         default:           return 2'd3 - elem;
      endcase
   endfunction

   function automatic logic [1:0] cell_col(dir_e dir, logic [1:0] line, logic [1:0] elem);
      case (dir)
         DirLeft:  return elem;
         DirRight: return 2'd3 - elem;
         default:  return line;
      endcase
   endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational compact-and-merge of one four-tile line toward element 0.
module line_merge
   import game_pkg::*;
(
   input  logic [3:0][11:0] line_in,
   output logic [3:0][11:0] line_out,
   output logic             changed
);

   logic [3:0][11:0] packed_q;
   logic [2:0]       n;
   logic [2:0]       m;
   logic             skip;

   always_comb begin
      packed_q = '0;
      n        = '0;
      for (int i = 0; i < 4; i++) begin
         if (line_in[i] != '0) begin
            packed_q[n[1:0]] = line_in[i];
            n                = n + 3'd1;
         end
      end

      // Zeros are trailing after compaction, so a pair check only needs the next slot.
      line_out = '0;
      m        = '0;
      skip     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (packed_q[i] != '0) begin
            if (i < 3 && packed_q[i] == packed_q[(i + 1) % 4]) begin
               line_out[m[1:0]] = packed_q[i] << 1;
               skip             = 1'b1;
            end else begin
               line_out[m[1:0]] = packed_q[i];
            end
            m = m + 3'd1;
         end
      end

      changed = (line_out != line_in);
   end

endmodule

// File: rtl/move_controller.sv
// Executes one 2048 move: four line passes through line_merge, optional tile spawn,
// a one-cycle write-back strobe, then win/lose evaluation.
module move_controller
   import game_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  move_valid,
   input  logic [1:0]            move_dir,
   output logic                  move_ready,
   input  logic [3:0][3:0][11:0] matrix_in,
   output logic [3:0][3:0][11:0] matrix_out,
   output logic                  matrix_we,
   output logic [2:0]            state,
   output logic                  done,
   output logic                  moved
);

   state_e     state_q;
   dir_e       dir_q;
   board_t     board_q;
   logic [1:0] line_q;
   logic       changed_q;
   logic [3:0] lfsr_q;
   logic       we_q;
   logic       done_q;
   logic       moved_q;

   logic [3:0][11:0] merge_in;
   logic [3:0][11:0] merge_out;
   logic             merge_changed;
   board_t           line_board;
   board_t           spawn_board;
   logic [3:0]       spawn_k;
   logic             spawn_found;
   logic             has_win;
   logic             has_zero;
   logic             has_pair;

   line_merge u_line_merge (
      .line_in  (merge_in),
      .line_out (merge_out),
      .changed  (merge_changed)
   );

   always_comb begin
      merge_in   = '0;
      line_board = board_q;
      for (int e = 0; e < 4; e++) begin
         merge_in[e] = board_q[cell_row(dir_q, line_q, 2'(e))][cell_col(dir_q, line_q, 2'(e))];
         line_board[cell_row(dir_q, line_q, 2'(e))][cell_col(dir_q, line_q, 2'(e))] =
            merge_out[e];
      end
   end

   // Scan flat index row*4+col upward from the LFSR value, wrapping 15 -> 0.
   always_comb begin
      spawn_board = board_q;
      spawn_k     = '0;
      spawn_found = 1'b0;
      for (int off = 0; off < 16; off++) begin
         spawn_k = lfsr_q + 4'(off);
         if (!spawn_found && board_q[spawn_k[3:2]][spawn_k[1:0]] == '0) begin
            spawn_board[spawn_k[3:2]][spawn_k[1:0]] = SpawnTile;
            spawn_found                             = 1'b1;
         end
      end
   end

   always_comb begin
      has_win  = 1'b0;
      has_zero = 1'b0;
      has_pair = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board_q[r][c] == WinTile) has_win = 1'b1;
            if (board_q[r][c] == '0) has_zero = 1'b1;
            if (c < 3 && board_q[r][c] == board_q[r][(c + 1) % 4]) has_pair = 1'b1;
            if (r < 3 && board_q[r][c] == board_q[(r + 1) % 4][c]) has_pair = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         dir_q     <= DirLeft;
         board_q   <= '0;
         line_q    <= '0;
         changed_q <= 1'b0;
         lfsr_q    <= 4'b0001;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         moved_q   <= 1'b0;
      end else begin
         lfsr_q  <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         moved_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (move_valid) begin
                  dir_q     <= dir_e'(move_dir);
                  board_q   <= matrix_in;
                  line_q    <= '0;
                  changed_q <= 1'b0;
                  state_q   <= StLine;
               end
            end
            StLine: begin
               board_q   <= line_board;
               changed_q <= changed_q | merge_changed;
               line_q    <= line_q + 2'd1;
               if (line_q == 2'd3) state_q <= StSpawn;
            end
            StSpawn: begin
               if (changed_q) board_q <= spawn_board;
               we_q    <= changed_q;
               done_q  <= 1'b1;
               moved_q <= changed_q;
               state_q <= StWrite;
            end
            StWrite: begin
               if (has_win)                   state_q <= StWin;
               else if (!has_zero && !has_pair) state_q <= StLose;
               else                           state_q <= StIdle;
            end
            StWin, StLose: state_q <= state_q;
            default:       state_q <= StIdle;
         endcase
      end
   end

   assign move_ready = (state_q == StIdle);
   assign matrix_out = board_q;
   assign matrix_we  = we_q;
   assign done       = done_q;
   assign moved      = moved_q;
   assign state      = state_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: hand-computed boards, spawn position from an LFSR model.
module tb_move_controller;
   import game_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       move_ready;
   board_t     matrix_in;
   board_t     matrix_out;
   logic       matrix_we;
   logic [2:0] state;
   logic       done;
   logic       moved;

   int tests = 0;
   int fails = 0;

   logic [3:0] lfsr_m;
   logic       r_done_early, r_done, r_we, r_moved, r_ready;
   logic [2:0] r_state;
   logic [3:0] r_lfsr;
   board_t     r_out;

   move_controller dut (
      .clk        (clk),
      .rst        (rst),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .move_ready (move_ready),
      .matrix_in  (matrix_in),
      .matrix_out (matrix_out),
      .matrix_we  (matrix_we),
      .state      (state),
      .done       (done),
      .moved      (moved)
   );

   always #5 clk = ~clk;

   // Reference x^4+x^3+1 generator, reset to 0001.
   always @(posedge clk) begin
      if (rst) lfsr_m <= 4'b0001;
      else     lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
   end

   function automatic board_t exp_spawn(board_t b, logic [3:0] l);
      board_t     r = b;
      logic [3:0] k;
      bit         found = 0;
      for (int off = 0; off < 16; off++) begin
         k = l + 4'(off);
         if (!found && r[k[3:2]][k[1:0]] == 12'd0) begin
            r[k[3:2]][k[1:0]] = 12'd2;
            found = 1;
         end
      end
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1; move_valid = 0; move_dir = 0; matrix_in = '0;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   // Accept at the edge after the first negedge; sample done at the 6th negedge, state at the 7th.
   task automatic run_move(input board_t b, input logic [1:0] dir, input bit noise);
      @(negedge clk);
      matrix_in = b; move_dir = dir; move_valid = 1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         move_valid = 0;
         if (noise && (k == 2 || k == 3)) begin
            move_valid = 1; move_dir = ~dir; matrix_in = '1;
         end
         if (k == 5) begin
            r_lfsr = lfsr_m; r_done_early = done;
         end
         if (k == 6) begin
            r_done = done; r_we = matrix_we; r_moved = moved; r_out = matrix_out;
         end
      end
      r_state = state; r_ready = move_ready;
   endtask

   task automatic test_reset();
      rst = 1; move_valid = 0; move_dir = 0; matrix_in = '0;
      repeat (2) @(negedge clk);
      tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
      tests++; if (matrix_we !== 1'b0 || done !== 1'b0 || moved !== 1'b0) begin
         fails++; $display("FAIL reset_strobes got we=%b done=%b moved=%b want 0", matrix_we, done, moved);
      end
      tests++; if (matrix_out !== '0) begin fails++; $display("FAIL reset_board got %h want 0", matrix_out); end
      rst = 0;
      @(negedge clk);
      tests++; if (move_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", move_ready); end
   endtask

   task automatic test_merge_left();
      board_t b = '0, e = '0;
      b[0][0] = 2; b[0][1] = 2; b[0][2] = 2; b[0][3] = 2;
      run_move(b, 2'd0, 0);
      e[0][0] = 4; e[0][1] = 4;
      e = exp_spawn(e, r_lfsr);
      tests++; if (r_done_early !== 1'b0) begin fails++; $display("FAIL latency_early_done got %b want 0", r_done_early); end
      tests++; if (r_done !== 1'b1 || r_we !== 1'b1 || r_moved !== 1'b1) begin
         fails++; $display("FAIL left_strobes got done=%b we=%b moved=%b want 111", r_done, r_we, r_moved);
      end
      tests++; if (r_out !== e) begin fails++; $display("FAIL left_board got %h want %h", r_out, e); end
      tests++; if (r_state !== 3'd0 || r_ready !== 1'b1) begin
         fails++; $display("FAIL left_idle got state=%0d ready=%b want 0/1", r_state, r_ready);
      end
      tests++; if (done !== 1'b0 || matrix_we !== 1'b0) begin
         fails++; $display("FAIL left_pulse_width got done=%b we=%b want 0", done, matrix_we);
      end
   endtask

   task automatic test_no_move();
      board_t b = '0;
      b[3][0] = 2;
      run_move(b, 2'd0, 0);
      tests++; if (r_done !== 1'b1 || r_we !== 1'b0 || r_moved !== 1'b0) begin
         fails++; $display("FAIL nomove_strobes got done=%b we=%b moved=%b want 100", r_done, r_we, r_moved);
      end
      tests++; if (r_out !== b) begin fails++; $display("FAIL nomove_board got %h want %h", r_out, b); end
      tests++; if (r_state !== 3'd0) begin fails++; $display("FAIL nomove_state got %0d want 0", r_state); end
   endtask

   task automatic test_patterns();
      board_t b = '0, e = '0;
      b[0][0] = 2; b[0][1] = 2; b[0][2] = 4;
      b[1][0] = 4; b[1][3] = 4;
      b[2][0] = 2; b[2][1] = 4; b[2][2] = 2; b[2][3] = 4;
      run_move(b, 2'd0, 0);
      e[0][0] = 4; e[0][1] = 4;
      e[1][0] = 8;
      e[2] = b[2];
      e = exp_spawn(e, r_lfsr);
      tests++; if (r_out !== e) begin fails++; $display("FAIL patterns_board got %h want %h", r_out, e); end
      tests++; if (r_moved !== 1'b1) begin fails++; $display("FAIL patterns_moved got %b want 1", r_moved); end
   endtask

   task automatic test_right_up();
      board_t b = '0, e = '0;
      b[0][0] = 2; b[0][1] = 2; b[0][2] = 2; b[0][3] = 2;
      run_move(b, 2'd1, 0);
      e[0][2] = 4; e[0][3] = 4;
      e = exp_spawn(e, r_lfsr);
      tests++; if (r_out !== e) begin fails++; $display("FAIL right_board got %h want %h", r_out, e); end
      b = '0; e = '0;
      b[0][1] = 4; b[1][1] = 4; b[2][1] = 8;
      run_move(b, 2'd2, 0);
      e[0][1] = 8; e[1][1] = 8;
      e = exp_spawn(e, r_lfsr);
      tests++; if (r_out !== e) begin fails++; $display("FAIL up_board got %h want %h", r_out, e); end
   endtask

   task automatic test_down();
      board_t b = '0, e = '0;
      logic   extra = 0;
      b[0][0] = 2; b[2][0] = 2; b[3][0] = 4;
      run_move(b, 2'd3, 1);
      e[2][0] = 4; e[3][0] = 4;
      e = exp_spawn(e, r_lfsr);
      tests++; if (r_out !== e) begin fails++; $display("FAIL down_board got %h want %h", r_out, e); end
      tests++; if (r_done !== 1'b1 || r_state !== 3'd0) begin
         fails++; $display("FAIL down_done got done=%b state=%0d want 1/0", r_done, r_state);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || state !== 3'd0) extra = 1;
      end
      tests++; if (extra !== 1'b0) begin fails++; $display("FAIL down_ignore_line got %b want 0", extra); end
   endtask

   task automatic test_win();
      board_t b = '0, e = '0;
      logic   bad = 0;
      b[0][0] = 1024; b[0][1] = 1024;
      run_move(b, 2'd0, 0);
      e[0][0] = 2048;
      e = exp_spawn(e, r_lfsr);
      tests++; if (r_out !== e) begin fails++; $display("FAIL win_board got %h want %h", r_out, e); end
      tests++; if (r_state !== 3'd4 || r_ready !== 1'b0) begin
         fails++; $display("FAIL win_state got state=%0d ready=%b want 4/0", r_state, r_ready);
      end
      move_valid = 1; matrix_in = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (state !== 3'd4 || done !== 1'b0 || matrix_we !== 1'b0 || move_ready !== 1'b0) bad = 1;
      end
      move_valid = 0;
      tests++; if (bad !== 1'b0) begin fails++; $display("FAIL win_absorbing got %b want 0", bad); end
   endtask

   task automatic test_lose();
      board_t b, e;
      do_reset();
      b[0][0] = 8;  b[0][1] = 8;  b[0][2] = 2;  b[0][3] = 4;
      b[1][0] = 32; b[1][1] = 64; b[1][2] = 32; b[1][3] = 64;
      b[2][0] = 64; b[2][1] = 32; b[2][2] = 64; b[2][3] = 32;
      b[3][0] = 32; b[3][1] = 64; b[3][2] = 32; b[3][3] = 64;
      run_move(b, 2'd0, 0);
      e = b;
      e[0][0] = 16; e[0][1] = 2; e[0][2] = 4; e[0][3] = 2;
      tests++; if (r_out !== e || r_we !== 1'b1) begin
         fails++; $display("FAIL lose_board got %h we=%b want %h we=1", r_out, r_we, e);
      end
      tests++; if (r_state !== 3'd5 || r_ready !== 1'b0) begin
         fails++; $display("FAIL lose_state got state=%0d ready=%b want 5/0", r_state, r_ready);
      end
   endtask

   task automatic test_reset_mid();
      board_t b = '0, e = '0;
      logic   we_seen = 0;
      do_reset();
      b[0][0] = 2; b[0][1] = 2;
      @(negedge clk);
      matrix_in = b; move_dir = 2'd0; move_valid = 1;
      @(negedge clk);
      move_valid = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      tests++; if (state !== 3'd0 || move_ready !== 1'b1) begin
         fails++; $display("FAIL midrst_state got state=%0d ready=%b want 0/1", state, move_ready);
      end
      tests++; if (matrix_out !== '0) begin fails++; $display("FAIL midrst_board got %h want 0", matrix_out); end
      rst = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (matrix_we !== 1'b0 || done !== 1'b0) we_seen = 1;
      end
      tests++; if (we_seen !== 1'b0) begin fails++; $display("FAIL midrst_no_write got %b want 0", we_seen); end
      run_move(b, 2'd0, 0);
      e[0][0] = 4;
      e = exp_spawn(e, r_lfsr);
      tests++; if (r_out !== e) begin fails++; $display("FAIL midrst_lfsr_spawn got %h want %h", r_out, e); end
   endtask

   initial begin
      test_reset();
      test_merge_left();
      test_no_move();
      test_patterns();
      test_right_up();
      test_down();
      test_win();
      test_lose();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port move_valid  in  1  move request from input decoder.
REQ-004 SHALL have port move_dir  in  2  direction: 0 left, 1 right, 2 up, 3 down.
REQ-005 SHALL have port move_ready  out  1  high only in IDLE.
REQ-006 SHALL have port matrix_in  in  12 x [3:0][3:0]  current board from state register, [row][col].
REQ-007 SHALL have port matrix_out  out  12 x [3:0][3:0]  next board to state register.
REQ-008 SHALL have port matrix_we  out  1  one-cycle write strobe for matrix_out.
REQ-009 SHALL have port state  out  3  current FSM encoding, written to state register together with matrix_out.
REQ-010 SHALL have port done  out  1  one-cycle pulse at move completion.
REQ-011 SHALL have port moved  out  1  valid with done; 1 if board changed.

Function
REQ-012 SHALL use FSM states IDLE=0, LINE=1, SPAWN=2, WRITE=3, WIN=4, LOSE=5.
REQ-013 SHALL accept a move on the edge where move_valid && move_ready: latch move_dir, copy matrix_in into work board, clear line counter and changed flag, go LINE.
REQ-014 SHALL ignore move_valid outside IDLE; no queuing.
REQ-015 SHALL process one line per LINE cycle, line index 0..3, then go SPAWN after line 3.
REQ-016 SHALL order line i elements: left row i col 0..3; right row i col 3..0; up col i row 0..3; down col i row 3..0; write back in same order.
REQ-017 SHALL compact non-zero tiles toward element 0, merge equal adjacent pairs from element 0 upward, each tile merging at most once; merged value = 2x (12-bit; max 2048, no overflow possible).
REQ-018 Merge examples SHALL hold: [2,2,2,2]->[4,4,0,0]; [2,2,4,0]->[4,4,0,0]; [4,0,0,4]->[8,0,0,0]; [2,4,2,4] unchanged.
REQ-019 SHALL set changed flag if any processed line differs from its input.
REQ-020 SPAWN, changed=1: place 2 at first zero cell scanning flat index k=row*4+col upward from lfsr value, wrapping 15->0; changed=0: board untouched. Always one cycle, then WRITE.
REQ-021 SHALL keep 4-bit LFSR (x^4+x^3+1), advancing every clock in all states.
REQ-022 WRITE: drive matrix_out=work board, done=1, moved=changed, matrix_we=changed; one cycle.
REQ-023 From WRITE SHALL go WIN if any tile equals 2048; else LOSE if no zero cell and no horizontally/vertically adjacent equal pair; else IDLE (win priority).
REQ-024 WIN and LOSE SHALL be absorbing until rst; move_ready=0 there.
REQ-025 Latency: done asserted exactly 6 cycles after accept edge (4 LINE, 1 SPAWN, WRITE), moved or not.
REQ-026 matrix_we, done, moved SHALL be 0 outside WRITE; state output always equals FSM register.

Reset
REQ-027 On rst: FSM IDLE, state=0, LFSR=4'b0001, line counter 0, changed 0, work board all zero, matrix_we/done/moved 0, move_ready 1 from next cycle.
REQ-028 rst mid-move SHALL abandon the move with no matrix_we pulse.

Structure
REQ-029 State encodings, direction codes, WIN_TILE=2048, SPAWN_TILE=2, board dimension SHALL live in shared package game_pkg.
REQ-030 Single-line compact/merge SHALL be combinational sub-module line_merge (4x12 in, 4x12 out, changed out), instantiated once.

Verification
REQ-031 Board row0=[2,2,2,2], rest 0, left -> after 6 cycles row0=[4,4,0,0] plus one spawned 2, moved=1, matrix_we=1, state=IDLE.
REQ-032 Only tile 2 at [3][0], move left -> done with moved=0, matrix_we=0, board unchanged, IDLE.
REQ-033 Row0=[1024,1024,0,0], left -> [0][0]=2048, state=WIN; later move_valid ignored, move_ready=0.
REQ-034 Full board, no equal neighbours except one zero cell filled via merge creating single empty cell, spawn fills it, no pairs remain -> state=LOSE.
REQ-035 Column0=[2,0,2,4] top-down, move down -> column0 top-down=[0,0,4,4] plus spawn; move_valid pulses during LINE ignored.
REQ-036 Assert rst during LINE cycle 2 -> next cycle IDLE, state=0, no matrix_we pulse, LFSR=0001.
